frame_sequencer: RTL and testbench
==================================

# frame_sequencer

Per-frame controller for the double-buffered framebuffer. Sequences each frame as back-buffer clear, draw and swap request, then waits for the vsync-synchronised buffer swap to complete before starting the next frame. Sits between the raster/clear engines and the swap buffer.
- Drives `swap_req` into the swap buffer.
- Observes that block's `side` output.
- Tells the write path which buffer is the back buffer.

## Interface
Parameters:
- `CLEAR_EN`, 1: 1 = run a clear pass before each draw; 0 = skip CLEAR.
- `WDOG_CYCLES`, 2**24: maximum cycles allowed in any wait state. 0 disables the watchdog.
- `FCNT_W`, 16: width of the frame counter.

Ports (one clock; reset is synchronous and active-high):
- `CLK`  in  1  system clock
- `rst`  in  1  synchronous active-high reset
- `enable`  in  1  level; run frames continuously while high
- `side`  in  1  current front-buffer index from the swap buffer
- `clr_start`  out  1  one-cycle pulse; start back-buffer clear
- `clr_done`  in  1  one-cycle pulse; clear finished
- `draw_start`  out  1  one-cycle pulse; start rendering
- `draw_done`  in  1  one-cycle pulse; rendering finished
- `swap_req`  out  1  one-cycle pulse to the swap buffer
- `back_sel`  out  1  buffer index the writers must target this frame
- `busy`  out  1  high in any state other than IDLE
- `frame_cnt`  out  FCNT_W  completed (swapped) frames, wraps modulo 2^FCNT_W
- `wdog_err`  out  1  sticky; a wait state timed out

## Operation
- States: IDLE, CLEAR, RENDER, SWAP_WAIT.
- IDLE → CLEAR when `enable`=1 (or → RENDER if `CLEAR_EN`=0).
  - On that edge: `back_sel` ← ~`side`.
  - Latched value holds for the whole frame.
- CLEAR: `clr_start` high in the first cycle only. Accepted `clr_done` → RENDER.
- RENDER: `draw_start` high in the first cycle only. Accepted `draw_done` → SWAP_WAIT.
- SWAP_WAIT:
  - `swap_req` high in the first cycle only; `side_at_req` ← `side` on entry.
  - Exit when `side` ≠ `side_at_req`. On that edge `frame_cnt` += 1.
  - Next state: CLEAR/RENDER (with `back_sel` re-latched ← ~`side`) if `enable`, else IDLE.
- `enable` falling mid-frame: the current frame completes through SWAP_WAIT, then IDLE. No abort.
- Done acceptance:
  - A done is accepted only in its own state and never in the cycle its start pulse is high.
  - Done pulses in any other state are ignored.
- Watchdog:
  - Counter clears on every state entry and increments each cycle in CLEAR/RENDER/SWAP_WAIT.
  - When it reaches `WDOG_CYCLES`-1: `wdog_err` ← 1, state → IDLE.
  - `wdog_err` clears only on `rst`. When set, IDLE does not restart even if `enable`=1.
- Reset (any state, mid-frame included): state IDLE, all pulses 0, `back_sel` 0, `busy` 0, `frame_cnt` 0, `wdog_err` 0, watchdog 0, `side_at_req` 0.

## Timing
- All outputs registered; no combinational input→output paths.
- `enable` sampled at edge N → start pulse (`clr_start`/`draw_start`) high in cycle N+1, `busy` high from N+1.
- Done accepted at edge M → next start pulse in cycle M+1 (one-cycle turnaround).
- `side` toggle sampled at edge K → `frame_cnt` updated and next `clr_start` in cycle K+1.
- With a bypassed-vsync swap buffer (`side` toggles the cycle after `swap_req`), SWAP_WAIT lasts 2 cycles.
- Minimum frame with `CLEAR_EN`=1 and one-cycle-later dones: 6 cycles.

## Structure
- Shared header `frame_seq_defs.vh`: 2-bit state encodings (IDLE=0, CLEAR=1, RENDER=2, SWAP_WAIT=3).
- Sub-module `wdog_timer`: clearable counter with terminal-count flag, disabled when the limit is 0. Watchdog counter width is derived from `WDOG_CYCLES`.
- The FSM, pulse generation and back_sel/frame_cnt registers stay in the top.

## Test plan
- Bypassed-vsync swap buffer model, `CLEAR_EN`=1, dones return 3 cycles after each start, `enable` held high for 4 frames.
  - Pulse order per frame: `clr_start`, `draw_start`, `swap_req`.
  - `frame_cnt` = 4; `back_sel` alternates 1,0,1,0 starting from `side`=0.
- `CLEAR_EN`=0:
  - No `clr_start` ever.
  - `enable`→`draw_start` latency 1 cycle.
- `enable` dropped during RENDER:
  - Frame still completes with `frame_cnt` +1.
  - FSM returns to IDLE, `busy`=0, no further pulses.
- Spurious `draw_done` during CLEAR, and `clr_done` in the same cycle as `clr_start`: both ignored, state unchanged.
- `WDOG_CYCLES`=16, `draw_done` never returned:
  - `wdog_err`=1 after 15 RENDER cycles, FSM in IDLE.
  - Stays idle with `enable`=1 until `rst`.
- `rst` asserted mid-SWAP_WAIT: all outputs at reset values the next cycle; a later `side` toggle causes no `frame_cnt` change.

Source files
------------

// File: rtl/frame_sequencer_pkg.sv
// Shared types and helpers for the per-frame sequencer: FSM state encoding
// and watchdog counter sizing.
package frame_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_CLEAR     = 2'd1,
    ST_RENDER    = 2'd2,
    ST_SWAP_WAIT = 2'd3
  } state_t;

  // The counter only has to reach limit-1, so clog2(limit) bits suffice.
  function automatic int unsigned wdog_width(input int unsigned limit);
    if (limit < 32'd2) begin
      return 32'd1;
    end else begin
      return $clog2(limit);
    end
  endfunction

endpackage

// File: rtl/frame_sequencer_wdog_timer.sv
// Clearable wait-state counter; tc fires on the cycle the count would reach
// LIMIT-1. A LIMIT of 0 disables the flag entirely.
module wdog_timer #(
  parameter int unsigned LIMIT = 32'd16,
  parameter int unsigned W     = 32'd4
) (
  input  logic CLK,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [W-1:0] count_r;

  assign tc = (LIMIT != 32'd0) && en &&
              ((32'(count_r) + 32'd1) >= (LIMIT - 32'd1));

  // Count cycles spent in the current wait state.
  always_ff @(posedge CLK) begin
    if (rst) begin
      count_r <= '0;
    end else if (clr) begin
      count_r <= '0;
    end else if (en) begin
      count_r <= count_r + W'(1);
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/frame_sequencer.sv
// Double-buffer frame controller: clear, draw, request swap, then wait for the
// front-buffer index to flip before starting the next frame.
module frame_sequencer
  import frame_sequencer_pkg::*;
#(
  parameter bit          CLEAR_EN    = 1'b1,
  parameter int unsigned WDOG_CYCLES = 32'd16777216,
  parameter int unsigned FCNT_W      = 32'd16
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              enable,
  input  logic              side,
  output logic              clr_start,
  input  logic              clr_done,
  output logic              draw_start,
  input  logic              draw_done,
  output logic              swap_req,
  output logic              back_sel,
  output logic              busy,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic              wdog_err
);

  localparam int unsigned WDOG_W = wdog_width(WDOG_CYCLES);

  state_t            state_r, next_state_s, first_state_s;
  logic              clr_start_r, draw_start_r, swap_req_r;
  logic              clr_start_s, draw_start_s, swap_req_s;
  logic              back_sel_r, busy_r, wdog_err_r, side_at_req_r;
  logic [FCNT_W-1:0] frame_cnt_r;
  logic              latch_back_s, frame_inc_s, wdog_tc_s, state_chg_s;

  assign first_state_s = CLEAR_EN ? ST_CLEAR : ST_RENDER;
  assign state_chg_s   = (next_state_s != state_r);

  wdog_timer #(
    .LIMIT (WDOG_CYCLES),
    .W     (WDOG_W)
  ) u_wdog (
    .CLK (CLK),
    .rst (rst),
    .clr (state_chg_s),
    .en  (state_r != ST_IDLE),
    .tc  (wdog_tc_s)
  );

  // Next-state selection and one-cycle start pulses on state entry.
  always_comb begin
    next_state_s = state_r;
    latch_back_s = 1'b0;
    frame_inc_s  = 1'b0;
    if (wdog_tc_s) begin
      next_state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (enable && !wdog_err_r) begin
            next_state_s = first_state_s;
            latch_back_s = 1'b1;
          end else begin
            next_state_s = ST_IDLE;
          end
        end
        ST_CLEAR: begin
          // A done coinciding with its own start pulse belongs to no pass.
          if (clr_done && !clr_start_r) begin
            next_state_s = ST_RENDER;
          end else begin
            next_state_s = ST_CLEAR;
          end
        end
        ST_RENDER: begin
          if (draw_done && !draw_start_r) begin
            next_state_s = ST_SWAP_WAIT;
          end else begin
            next_state_s = ST_RENDER;
          end
        end
        ST_SWAP_WAIT: begin
          if (side != side_at_req_r) begin
            frame_inc_s = 1'b1;
            if (enable) begin
              next_state_s = first_state_s;
              latch_back_s = 1'b1;
            end else begin
              next_state_s = ST_IDLE;
            end
          end else begin
            next_state_s = ST_SWAP_WAIT;
          end
        end
        default: begin
          next_state_s = ST_IDLE;
        end
      endcase
    end
    clr_start_s  = state_chg_s && (next_state_s == ST_CLEAR);
    draw_start_s = state_chg_s && (next_state_s == ST_RENDER);
    swap_req_s   = state_chg_s && (next_state_s == ST_SWAP_WAIT);
  end

  // State, pulse and per-frame registers.
  always_ff @(posedge CLK) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      clr_start_r   <= 1'b0;
      draw_start_r  <= 1'b0;
      swap_req_r    <= 1'b0;
      back_sel_r    <= 1'b0;
      busy_r        <= 1'b0;
      frame_cnt_r   <= '0;
      wdog_err_r    <= 1'b0;
      side_at_req_r <= 1'b0;
    end else begin
      state_r      <= next_state_s;
      clr_start_r  <= clr_start_s;
      draw_start_r <= draw_start_s;
      swap_req_r   <= swap_req_s;
      busy_r       <= (next_state_s != ST_IDLE);
      if (latch_back_s) begin
        back_sel_r <= ~side;
      end
      if (swap_req_s) begin
        side_at_req_r <= side;
      end
      if (frame_inc_s) begin
        frame_cnt_r <= frame_cnt_r + FCNT_W'(1);
      end
      if (wdog_tc_s) begin
        wdog_err_r <= 1'b1;
      end
    end
  end

  assign clr_start  = clr_start_r;
  assign draw_start = draw_start_r;
  assign swap_req   = swap_req_r;
  assign back_sel   = back_sel_r;
  assign busy       = busy_r;
  assign frame_cnt  = frame_cnt_r;
  assign wdog_err   = wdog_err_r;

endmodule

// File: tb/tb_frame_sequencer.sv
// Randomised bench for frame_sequencer: instance 0 runs with a clear pass,
// instance 1 without; both use a short watchdog limit of 16.
module tb_frame_sequencer;

  logic       CLK = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] enable = 2'b00;
  logic [1:0] side = 2'b00;
  logic [1:0] clr_done = 2'b00;
  logic [1:0] draw_done = 2'b00;
  logic [1:0] clr_start, draw_start, swap_req, back_sel, busy, wdog_err;
  logic [15:0] frame_cnt [2];

  int n_chk = 0;
  int n_fail = 0;
  int exp_cnt [2];
  logic exp_back [2];

  always #5 CLK = ~CLK;

  frame_sequencer #(.CLEAR_EN(1'b1), .WDOG_CYCLES(32'd16), .FCNT_W(32'd16)) u_dut0 (
    .CLK(CLK), .rst(rst), .enable(enable[0]), .side(side[0]),
    .clr_start(clr_start[0]), .clr_done(clr_done[0]),
    .draw_start(draw_start[0]), .draw_done(draw_done[0]),
    .swap_req(swap_req[0]), .back_sel(back_sel[0]), .busy(busy[0]),
    .frame_cnt(frame_cnt[0]), .wdog_err(wdog_err[0])
  );

  frame_sequencer #(.CLEAR_EN(1'b0), .WDOG_CYCLES(32'd16), .FCNT_W(32'd16)) u_dut1 (
    .CLK(CLK), .rst(rst), .enable(enable[1]), .side(side[1]),
    .clr_start(clr_start[1]), .clr_done(clr_done[1]),
    .draw_start(draw_start[1]), .draw_done(draw_done[1]),
    .swap_req(swap_req[1]), .back_sel(back_sel[1]), .busy(busy[1]),
    .frame_cnt(frame_cnt[1]), .wdog_err(wdog_err[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_idle(input int u, input int n);
    for (int i = 0; i < n; i++) begin
      step();
      chk($sformatf("u%0d idle busy", u), 32'(busy[u]), 32'd0);
      chk($sformatf("u%0d idle pulses", u),
          32'({clr_start[u], draw_start[u], swap_req[u]}), 32'd0);
      chk($sformatf("u%0d idle frame_cnt", u), 32'(frame_cnt[u]), 32'(exp_cnt[u]));
    end
  endtask

  // Raise enable from IDLE; the first start pulse must follow one cycle later.
  task automatic start(input int u);
    chk($sformatf("u%0d pre-start busy", u), 32'(busy[u]), 32'd0);
    enable[u] = 1'b1;
    exp_back[u] = ~side[u];
    step();
    chk($sformatf("u%0d start busy", u), 32'(busy[u]), 32'd1);
  endtask

  // One frame starting in its first cycle. dc/dd: cycles from start pulse to
  // done; v: cycles from swap_req until the front index flips.
  task automatic frame(input int u, input int dc, input int dd, input int v,
                       input bit drop, input bit rst_swap);
    if (u == 0) begin
      chk("u0 clr_start", 32'(clr_start[u]), 32'd1);
      chk("u0 clear back_sel", 32'(back_sel[u]), 32'(exp_back[u]));
      clr_done[u]  = 1'($urandom_range(1));
      draw_done[u] = 1'($urandom_range(1));
      for (int k = 1; k <= dc; k++) begin
        step();
        clr_done[u] = 1'b0;
        draw_done[u] = 1'b0;
        chk("u0 clear no pulse", 32'({clr_start[u], draw_start[u]}), 32'd0);
        if (k == dc) clr_done[u] = 1'b1;
        else draw_done[u] = 1'($urandom_range(1));
      end
      step();
      clr_done[u] = 1'b0;
      draw_done[u] = 1'b0;
    end
    chk($sformatf("u%0d draw_start", u), 32'(draw_start[u]), 32'd1);
    chk($sformatf("u%0d no clr_start", u), 32'(clr_start[u]), 32'd0);
    chk($sformatf("u%0d render back_sel", u), 32'(back_sel[u]), 32'(exp_back[u]));
    draw_done[u] = 1'($urandom_range(1));
    clr_done[u]  = 1'($urandom_range(1));
    if (drop) enable[u] = 1'b0;
    for (int k = 1; k <= dd; k++) begin
      step();
      clr_done[u] = 1'b0;
      draw_done[u] = 1'b0;
      chk($sformatf("u%0d render no pulse", u),
          32'({clr_start[u], draw_start[u], swap_req[u]}), 32'd0);
      if (k == dd) draw_done[u] = 1'b1;
      else clr_done[u] = 1'($urandom_range(1));
    end
    step();
    clr_done[u] = 1'b0;
    draw_done[u] = 1'b0;
    chk($sformatf("u%0d swap_req", u), 32'(swap_req[u]), 32'd1);
    if (rst_swap) begin
      rst = 1'b1;
      step();
      rst = 1'b0;
      enable[u] = 1'b0;
      exp_cnt[0] = 0;
      exp_cnt[1] = 0;
      chk("rst outputs", 32'({clr_start[u], draw_start[u], swap_req[u],
                              back_sel[u], busy[u], wdog_err[u]}), 32'd0);
      chk("rst frame_cnt", 32'(frame_cnt[u]), 32'd0);
      side[u] = ~side[u];
      chk_idle(u, 3);
      return;
    end
    for (int k = 1; k <= v; k++) begin
      step();
      chk($sformatf("u%0d swap wait", u), 32'({swap_req[u], busy[u]}), 32'd1);
      chk($sformatf("u%0d cnt held", u), 32'(frame_cnt[u]), 32'(exp_cnt[u]));
      if (k == v) side[u] = ~side[u];
    end
    step();
    exp_cnt[u] = (exp_cnt[u] + 1) % 65536;
    chk($sformatf("u%0d frame_cnt", u), 32'(frame_cnt[u]), 32'(exp_cnt[u]));
    if (enable[u]) begin
      exp_back[u] = ~side[u];
      chk($sformatf("u%0d next busy", u), 32'(busy[u]), 32'd1);
    end else begin
      chk($sformatf("u%0d end busy", u), 32'(busy[u]), 32'd0);
      chk($sformatf("u%0d end pulses", u),
          32'({clr_start[u], draw_start[u], swap_req[u]}), 32'd0);
    end
  endtask

  initial begin
    exp_cnt[0] = 0;
    exp_cnt[1] = 0;
    repeat (2) step();
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("u%0d reset outputs", u),
          32'({clr_start[u], draw_start[u], swap_req[u], back_sel[u], busy[u], wdog_err[u]}),
          32'd0);
      chk($sformatf("u%0d reset frame_cnt", u), 32'(frame_cnt[u]), 32'd0);
    end
    rst = 1'b0;
    chk_idle(0, 2);

    // Four back-to-back frames, bypassed vsync, dones 3 cycles after starts.
    start(0);
    for (int f = 0; f < 4; f++) begin
      chk("u0 back_sel alternates", 32'(back_sel[0]), (f % 2 == 0) ? 32'd1 : 32'd0);
      frame(0, 3, 3, 1, f == 3, 1'b0);
    end
    chk("u0 four frames", 32'(frame_cnt[0]), 32'd4);
    chk_idle(0, 3);

    // Randomised frames with a clear pass.
    start(0);
    for (int f = 0; f < 6; f++) begin
      frame(0, int'($urandom_range(6, 1)), int'($urandom_range(6, 1)),
            int'($urandom_range(3, 1)), f == 5, 1'b0);
    end
    chk_idle(0, 3);

    // Randomised frames without a clear pass.
    start(1);
    for (int f = 0; f < 6; f++) begin
      frame(1, 1, int'($urandom_range(6, 1)), int'($urandom_range(3, 1)), f == 5, 1'b0);
    end
    chk_idle(1, 3);

    // Reset while waiting for the swap.
    start(0);
    frame(0, 2, 2, 1, 1'b0, 1'b1);

    // Watchdog: draw_done is never returned.
    start(0);
    chk("wd clr_start", 32'(clr_start[0]), 32'd1);
    step();
    clr_done[0] = 1'b1;
    step();
    clr_done[0] = 1'b0;
    chk("wd draw_start", 32'(draw_start[0]), 32'd1);
    for (int k = 2; k <= 15; k++) begin
      step();
      chk("wd not yet", 32'({wdog_err[0], busy[0]}), 32'd1);
    end
    step();
    chk("wd err set", 32'(wdog_err[0]), 32'd1);
    chk("wd idle", 32'(busy[0]), 32'd0);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("wd stays idle", 32'({busy[0], clr_start[0], draw_start[0], swap_req[0]}), 32'd0);
      chk("wd sticky", 32'(wdog_err[0]), 32'd1);
    end
    rst = 1'b1;
    enable[0] = 1'b0;
    step();
    rst = 1'b0;
    exp_cnt[0] = 0;
    exp_cnt[1] = 0;
    chk("wd cleared by rst", 32'(wdog_err[0]), 32'd0);
    chk_idle(0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
